// File: rtl/iq_symbol_sched.sv
// IQ symbol scheduler: buffers 8-bit {i,q} symbols in a 4-entry FIFO and
// plays them out to the modulator one symbol per SYMLEN clocks. Each burst
// starts with an optional preamble and ends with a one-symbol zero tail.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | outputs zero, waiting for enable with at least one queued symbol
// PRE   | presenting PRE_IQ for PRE_SYMS symbol periods, FIFO untouched
// DATA  | presenting the symbol most recently popped from the FIFO
// TAIL  | outputs zero for one full symbol period before returning to IDLE

module iq_symbol_sched #(
    parameter int         SYMLEN   = 16,
    parameter int         PRE_SYMS = 2,
    parameter logic [7:0] PRE_IQ   = 8'h70
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sym_in,
    input  logic       sym_valid,
    output logic       sym_ready,
    input  logic       enable,
    output logic [3:0] i,
    output logic [3:0] q,
    output logic       sym_strobe,
    output logic       busy,
    output logic       underrun
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_TAIL = 2'd3;

    localparam logic [7:0] SCTR_LAST = 8'(SYMLEN - 1);
    // With no preamble the PRE state is unreachable, so the value is unused.
    localparam logic [3:0] PCTR_LAST = (PRE_SYMS > 0) ? 4'(PRE_SYMS - 1) : 4'd0;
    localparam bit         HAS_PRE   = (PRE_SYMS > 0);

    // FIFO storage and bookkeeping
    logic [3:0][7:0] mem_q, mem_d;
    logic [1:0]      wr_ptr_q, wr_ptr_d;
    logic [1:0]      rd_ptr_q, rd_ptr_d;
    logic [2:0]      count_q, count_d;

    // Sequencer state and registered outputs
    logic [1:0]      state_q, state_d;
    logic [7:0]      sctr_q, sctr_d;
    logic [3:0]      pctr_q, pctr_d;
    logic [7:0]      iq_q, iq_d;
    logic            strobe_q, strobe_d;
    logic            busy_q, busy_d;
    logic            underrun_q, underrun_d;

    logic            push;
    logic            pop_req;
    logic            pop;
    logic            fifo_empty;
    logic [7:0]      fifo_head;
    logic            boundary;

    assign sym_ready  = (count_q < 3'd4);
    assign fifo_empty = (count_q == 3'd0);
    assign fifo_head  = mem_q[rd_ptr_q];
    assign push       = sym_valid & sym_ready;
    // The sequencer only requests a pop when the FIFO holds data; the guard
    // keeps the pointers consistent even if that ever stopped being true.
    assign pop        = pop_req & ~fifo_empty;
    assign boundary   = (sctr_q == SCTR_LAST);

    assign i          = iq_q[7:4];
    assign q          = iq_q[3:0];
    assign sym_strobe = strobe_q;
    assign busy       = busy_q;
    assign underrun   = underrun_q;

    // FIFO next-state: write at wr_ptr, read at rd_ptr, count tracks occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = sym_in;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // Sequencer: symbol timing, preamble count, and what to present next
    always_comb begin
        state_d    = state_q;
        sctr_d     = sctr_q;
        pctr_d     = pctr_q;
        iq_d       = iq_q;
        strobe_d   = 1'b0;
        underrun_d = 1'b0;
        pop_req    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sctr_d = '0;
                pctr_d = '0;
                iq_d   = '0;
                if (enable && !fifo_empty) begin
                    strobe_d = 1'b1;
                    if (HAS_PRE) begin
                        state_d = ST_PRE;
                        iq_d    = PRE_IQ;
                    end else begin
                        state_d = ST_DATA;
                        iq_d    = fifo_head;
                        pop_req = 1'b1;
                    end
                end
            end
            ST_PRE, ST_DATA: begin
                if (!boundary) begin
                    sctr_d = sctr_q + 8'd1;
                end else begin
                    sctr_d = '0;
                    if (!enable) begin
                        // Enable is only acted on here, so a symbol in
                        // flight always runs its full period.
                        state_d = ST_TAIL;
                        iq_d    = '0;
                    end else if (state_q == ST_PRE && pctr_q != PCTR_LAST) begin
                        pctr_d   = pctr_q + 4'd1;
                        strobe_d = 1'b1;
                    end else if (!fifo_empty) begin
                        state_d  = ST_DATA;
                        iq_d     = fifo_head;
                        pop_req  = 1'b1;
                        strobe_d = 1'b1;
                    end else begin
                        state_d    = ST_TAIL;
                        iq_d       = '0;
                        underrun_d = 1'b1;
                    end
                end
            end
            ST_TAIL: begin
                iq_d = '0;
                if (boundary) begin
                    state_d = ST_IDLE;
                    sctr_d  = '0;
                    pctr_d  = '0;
                end else begin
                    sctr_d = sctr_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sctr_d  = '0;
                pctr_d  = '0;
                iq_d    = '0;
            end
        endcase
    end

    // busy is registered alongside the state so it lines up with i/q
    always_comb begin
        busy_d = (state_d != ST_IDLE);
    end

    // All state registers; reset wins over any push, pop or transition
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            sctr_q     <= '0;
            pctr_q     <= '0;
            iq_q       <= '0;
            strobe_q   <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            sctr_q     <= sctr_d;
            pctr_q     <= pctr_d;
            iq_q       <= iq_d;
            strobe_q   <= strobe_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_iq_symbol_sched.sv
// Bench for iq_symbol_sched: two instances (default parameters, and
// SYMLEN=2 / PRE_SYMS=0) checked every cycle against a queue-and-countdown
// model of the playout rules, plus directed scenarios with literal values.

module tb_iq_symbol_sched;

    localparam int M_IDLE = 0;
    localparam int M_PRE  = 1;
    localparam int M_DATA = 2;
    localparam int M_TAIL = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sym_in0, sym_in1;
    logic       sym_valid0, sym_valid1;
    logic       enable0, enable1;
    logic       sym_ready0, sym_ready1;
    logic [3:0] i0, q0, i1, q1;
    logic       sym_strobe0, sym_strobe1;
    logic       busy0, busy1;
    logic       underrun0, underrun1;

    int checks   = 0;
    int failures = 0;
    bit model_live = 1'b0;
    bit go1  = 1'b0;
    bit done = 1'b0;
    bit acc_tmp;

    // model state, index 0 = default instance, 1 = short/no-preamble instance
    logic [7:0] m_fifo [2][4];
    int         m_cnt [2];
    int         m_mode [2];
    int         m_rem [2];
    int         m_pre_left [2];
    logic [7:0] m_out [2];
    bit         m_strobe [2];
    bit         m_under [2];

    always #5 clk = ~clk;

    iq_symbol_sched u_dut0 (
        .clk(clk), .rst(rst), .sym_in(sym_in0), .sym_valid(sym_valid0),
        .sym_ready(sym_ready0), .enable(enable0), .i(i0), .q(q0),
        .sym_strobe(sym_strobe0), .busy(busy0), .underrun(underrun0)
    );

    iq_symbol_sched #(.SYMLEN(2), .PRE_SYMS(0), .PRE_IQ(8'h70)) u_dut1 (
        .clk(clk), .rst(rst), .sym_in(sym_in1), .sym_valid(sym_valid1),
        .sym_ready(sym_ready1), .enable(enable1), .i(i1), .q(q1),
        .sym_strobe(sym_strobe1), .busy(busy1), .underrun(underrun1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] m_pop(input int k);
        logic [7:0] head;
        head = m_fifo[k][0];
        for (int j = 0; j < 3; j++) m_fifo[k][j] = m_fifo[k][j+1];
        m_cnt[k]--;
        return head;
    endfunction

    // One clock of the reference: inputs as seen at the rising edge
    task automatic model_step(input int k, input int symlen, input int pre_syms,
                              input logic [7:0] pre_iq, input logic r,
                              input logic v, input logic [7:0] din, input logic en);
        bit acc;
        if (r) begin
            m_cnt[k] = 0; m_mode[k] = M_IDLE; m_rem[k] = 0; m_pre_left[k] = 0;
            m_out[k] = 8'h00; m_strobe[k] = 1'b0; m_under[k] = 1'b0;
            return;
        end
        acc = v && (m_cnt[k] < 4);
        m_strobe[k] = 1'b0;
        m_under[k]  = 1'b0;
        if (m_mode[k] == M_IDLE) begin
            if (en && m_cnt[k] > 0) begin
                m_rem[k] = symlen;
                m_strobe[k] = 1'b1;
                if (pre_syms > 0) begin
                    m_mode[k] = M_PRE; m_pre_left[k] = pre_syms - 1; m_out[k] = pre_iq;
                end else begin
                    m_mode[k] = M_DATA; m_out[k] = m_pop(k);
                end
            end
        end else if (m_rem[k] > 1) begin
            m_rem[k]--;
        end else begin
            m_rem[k] = symlen;
            if (m_mode[k] == M_TAIL) begin
                m_mode[k] = M_IDLE;
            end else if (!en) begin
                m_mode[k] = M_TAIL; m_out[k] = 8'h00;
            end else if (m_mode[k] == M_PRE && m_pre_left[k] > 0) begin
                m_pre_left[k]--; m_strobe[k] = 1'b1;
            end else if (m_cnt[k] > 0) begin
                m_mode[k] = M_DATA; m_out[k] = m_pop(k); m_strobe[k] = 1'b1;
            end else begin
                m_mode[k] = M_TAIL; m_out[k] = 8'h00; m_under[k] = 1'b1;
            end
        end
        if (acc) begin
            m_fifo[k][m_cnt[k]] = din;
            m_cnt[k]++;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 16, 2, 8'h70, rst, sym_valid0, sym_in0, enable0);
        model_step(1, 2, 0, 8'h70, rst, sym_valid1, sym_in1, enable1);
        if (rst) model_live = 1'b1;
    end

    task automatic cmp(input int k, input logic [3:0] ai, input logic [3:0] aq,
                       input logic as, input logic ab, input logic au, input logic ar);
        string p;
        p = $sformatf("dut%0d", k);
        chk({p, "_i"},        int'(ai), int'(m_out[k][7:4]));
        chk({p, "_q"},        int'(aq), int'(m_out[k][3:0]));
        chk({p, "_strobe"},   int'(as), int'(m_strobe[k]));
        chk({p, "_busy"},     int'(ab), (m_mode[k] != M_IDLE) ? 1 : 0);
        chk({p, "_underrun"}, int'(au), int'(m_under[k]));
        chk({p, "_ready"},    int'(ar), (m_cnt[k] < 4) ? 1 : 0);
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (model_live) begin
            cmp(0, i0, q0, sym_strobe0, busy0, underrun0, sym_ready0);
            cmp(1, i1, q1, sym_strobe1, busy1, underrun1, sym_ready1);
        end
    end

    // Short-symbol instance: no preamble, SYMLEN=2, then random traffic
    initial begin
        sym_in1 = 8'h00; sym_valid1 = 1'b0; enable1 = 1'b0;
        wait (go1);
        sym_valid1 = 1'b1;
        sym_in1 = 8'h91; tick();
        sym_in1 = 8'h92; tick();
        sym_in1 = 8'h93; tick();
        sym_valid1 = 1'b0;
        enable1 = 1'b1;
        tick();
        chk("nopre_first_i", int'(i1), 'h9);
        chk("nopre_first_q", int'(q1), 'h1);
        chk("nopre_first_strobe", int'(sym_strobe1), 1);
        tick();
        chk("nopre_mid_strobe", int'(sym_strobe1), 0);
        tick();
        chk("nopre_second_q", int'(q1), 'h2);
        chk("nopre_second_strobe", int'(sym_strobe1), 1);
        tick(); tick();
        chk("nopre_third_q", int'(q1), 'h3);
        chk("nopre_third_strobe", int'(sym_strobe1), 1);
        tick(); tick();
        chk("nopre_underrun", int'(underrun1), 1);
        tick(); tick();
        chk("nopre_idle_busy", int'(busy1), 0);
        while (!done) begin
            sym_valid1 = ($urandom_range(0, 3) == 0);
            sym_in1    = 8'($urandom);
            enable1    = ($urandom_range(0, 9) != 0);
            tick();
        end
        sym_valid1 = 1'b0;
    end

    // Default instance: directed scenarios, then randomized traffic
    initial begin
        rst = 1'b1; sym_in0 = 8'h00; sym_valid0 = 1'b0; enable0 = 1'b0;
        tick(); tick();
        chk("reset_i", int'(i0), 0);
        chk("reset_q", int'(q0), 0);
        chk("reset_busy", int'(busy0), 0);
        chk("reset_ready", int'(sym_ready0), 1);
        chk("reset_strobe", int'(sym_strobe0), 0);
        rst = 1'b0;
        go1 = 1'b1;

        // basic stream: two symbols, enable held
        sym_valid0 = 1'b1;
        sym_in0 = 8'h3C; tick();
        sym_in0 = 8'hA5; tick();
        sym_valid0 = 1'b0;
        enable0 = 1'b1;
        tick();
        chk("basic_pre_i", int'(i0), 'h7);
        chk("basic_pre_q", int'(q0), 'h0);
        chk("basic_pre_strobe", int'(sym_strobe0), 1);
        chk("basic_pre_busy", int'(busy0), 1);
        repeat (31) tick();
        chk("basic_pre_last_i", int'(i0), 'h7);
        tick();
        chk("basic_d0_i", int'(i0), 'h3);
        chk("basic_d0_q", int'(q0), 'hC);
        chk("basic_d0_strobe", int'(sym_strobe0), 1);
        repeat (16) tick();
        chk("basic_d1_i", int'(i0), 'hA);
        chk("basic_d1_q", int'(q0), 'h5);
        repeat (16) tick();
        chk("basic_underrun", int'(underrun0), 1);
        chk("basic_tail_i", int'(i0), 0);
        chk("basic_tail_strobe", int'(sym_strobe0), 0);
        repeat (15) tick();
        chk("basic_tail_busy", int'(busy0), 1);
        tick();
        chk("basic_end_busy", int'(busy0), 0);
        enable0 = 1'b0;

        // backpressure: six back-to-back offers into an idle block
        sym_valid0 = 1'b1;
        for (int n = 0; n < 6; n++) begin
            sym_in0 = 8'(17 * (n + 1));
            tick();
            if (n == 3) chk("bp_ready_after_4", int'(sym_ready0), 0);
            if (n == 5) chk("bp_ready_after_6", int'(sym_ready0), 0);
        end
        sym_valid0 = 1'b0;

        // enable drop in the middle of the second data symbol
        enable0 = 1'b1;
        tick();
        repeat (32) tick();
        chk("drop_d0", int'({i0, q0}), 'h11);
        repeat (16) tick();
        chk("drop_d1", int'({i0, q0}), 'h22);
        repeat (5) tick();
        enable0 = 1'b0;
        repeat (10) tick();
        chk("drop_d1_last", int'({i0, q0}), 'h22);
        tick();
        chk("drop_tail_iq", int'({i0, q0}), 0);
        chk("drop_no_underrun", int'(underrun0), 0);
        chk("drop_tail_busy", int'(busy0), 1);
        repeat (16) tick();
        chk("drop_idle", int'(busy0), 0);
        enable0 = 1'b1;
        tick();
        repeat (32) tick();
        chk("drop_kept_33", int'({i0, q0}), 'h33);
        repeat (16) tick();
        chk("drop_kept_44", int'({i0, q0}), 'h44);
        repeat (16) tick();
        chk("drop_final_underrun", int'(underrun0), 1);
        repeat (16) tick();
        enable0 = 1'b0;

        // refill while full: pop and push meet around a full FIFO
        sym_valid0 = 1'b1;
        sym_in0 = 8'hAA; tick();
        sym_in0 = 8'hBB; tick();
        sym_in0 = 8'hCC; tick();
        sym_in0 = 8'hDD; tick();
        sym_in0 = 8'hEE;
        enable0 = 1'b1;
        tick();
        for (int c = 1; c <= 96; c++) begin
            acc_tmp = sym_ready0;
            tick();
            if (acc_tmp) sym_in0 = sym_in0 + 8'd1;
            if (c == 32) begin
                chk("full_first_AA", int'({i0, q0}), 'hAA);
                chk("full_ready_after_pop", int'(sym_ready0), 1);
            end
            if (c == 33) chk("full_ready_refilled", int'(sym_ready0), 0);
            if (c == 48) chk("full_order_BB", int'({i0, q0}), 'hBB);
            if (c == 96) chk("full_order_EE", int'({i0, q0}), 'hEE);
        end
        sym_valid0 = 1'b0;
        enable0 = 1'b0;
        repeat (40) tick();

        // reset in the middle of a data symbol
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst2_ready", int'(sym_ready0), 1);
        sym_valid0 = 1'b1;
        sym_in0 = 8'h12; tick();
        sym_in0 = 8'h34; tick();
        sym_valid0 = 1'b0;
        enable0 = 1'b1;
        tick();
        repeat (32) tick();
        chk("mid_d0", int'({i0, q0}), 'h12);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_iq", int'({i0, q0}), 0);
        chk("mid_rst_busy", int'(busy0), 0);
        chk("mid_rst_ready", int'(sym_ready0), 1);
        chk("mid_rst_strobe", int'(sym_strobe0), 0);
        rst = 1'b0;
        sym_valid0 = 1'b1;
        sym_in0 = 8'h5A;
        tick();
        sym_valid0 = 1'b0;
        tick();
        chk("restart_pre_iq", int'({i0, q0}), 'h70);
        chk("restart_pre_strobe", int'(sym_strobe0), 1);
        repeat (32) tick();
        chk("restart_d0", int'({i0, q0}), 'h5A);
        repeat (40) tick();

        // randomized traffic with varying offer density
        for (int blk = 0; blk < 6; blk++) begin
            int dens;
            dens = (blk % 3 == 0) ? 0 : ((blk % 3 == 1) ? 20 : 60);
            for (int c = 0; c < 500; c++) begin
                rst        = ($urandom_range(0, 399) == 0);
                sym_valid0 = ($urandom_range(0, dens) == 0);
                sym_in0    = 8'($urandom);
                enable0    = ($urandom_range(0, 15) != 0);
                tick();
            end
        end
        rst = 1'b0;
        sym_valid0 = 1'b0;
        done = 1'b1;
        repeat (5) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
